// File: rtl/edge_pkg.sv
// Shared types and sizes for the edge-detection pipeline.
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_WE,
        BUS,
        DONE
    } b2_state_t;

    localparam int B2_DEPTH = 9;
    localparam int PIX_W    = 8;

endpackage

// File: rtl/b2_fifo.sv
// B2 pixel store: circular buffer with wrapping pointers and occupancy count.
module b2_fifo
    import edge_pkg::*;
#(
    parameter int DEPTH  = B2_DEPTH,
    parameter int DATA_W = PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       push_ok,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] cnt_nxt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              pop_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= inc(wr_ptr);
            if (pop_ok)  rd_ptr <= inc(rd_ptr);
            count <= cnt_nxt;
        end
    end

endmodule

// File: rtl/b2_write_buffer.sv
// B2 output buffer: queues gradient pixels and drains them to the write bus.
// Optional sticky error flag o_err when B2_ERR_FLAG_EN is defined.
module b2_write_buffer
    import edge_pkg::*;
#(
    parameter int DEPTH  = B2_DEPTH,
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_b2_save,
    input  logic [DATA_W-1:0] i_grad_pixel,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_bus_ack,
    output logic              o_bus_wr,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [BUS_W-1:0]  o_bus_wdata,
    output logic              o_start_next_write,
    output logic              o_write_complete,
    output logic              o_b2_empty,
    output logic              o_b2_full
`ifdef B2_ERR_FLAG_EN
   ,output logic              o_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    b2_state_t         state;
    logic [DATA_W-1:0] rd_data;
    logic              push_ok;
    logic              f_empty;
    logic [CW-1:0]     cnt_nxt;
    logic              pop;

    assign pop = (state == WAIT_WE) && i_we && !f_empty;

    b2_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (i_b2_save),
        .pop     (pop),
        .wr_data (i_grad_pixel),
        .rd_data (rd_data),
        .push_ok (push_ok),
        .empty   (f_empty),
        .cnt_nxt (cnt_nxt)
    );

    // Outputs are set on entry so each one coincides with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            o_bus_wr           <= 1'b0;
            o_bus_addr         <= '0;
            o_bus_wdata        <= '0;
            o_start_next_write <= 1'b0;
            o_write_complete   <= 1'b0;
            o_b2_empty         <= 1'b1;
            o_b2_full          <= 1'b0;
        end else begin
            o_start_next_write <= 1'b0;
            o_write_complete   <= 1'b0;
            o_b2_empty         <= (cnt_nxt == '0);
            o_b2_full          <= (cnt_nxt == CW'(DEPTH));
            unique case (state)
                IDLE: begin
                    if (!f_empty || push_ok) begin
                        state              <= START;
                        o_start_next_write <= 1'b1;
                    end
                end
                START: state <= WAIT_WE;
                WAIT_WE: begin
                    if (pop) begin
                        state       <= BUS;
                        o_bus_wr    <= 1'b1;
                        o_bus_addr  <= i_waddr;
                        o_bus_wdata <= BUS_W'(rd_data);
                    end
                end
                BUS: begin
                    if (i_bus_ack) begin
                        state            <= DONE;
                        o_bus_wr         <= 1'b0;
                        o_write_complete <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef B2_ERR_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) o_err <= 1'b0;
        else if ((i_b2_save && !push_ok) || (i_we && f_empty)) o_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_b2_write_buffer.sv
// Bench for b2_write_buffer: pixel scoreboard, fill table, drain and corner sequences.
module tb_b2_write_buffer;
    import edge_pkg::*;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_b2_save = 1'b0;
    logic [7:0]  i_grad_pixel = '0;
    logic        i_we = 1'b0;
    logic [31:0] i_waddr = '0;
    logic        i_bus_ack = 1'b0;
    logic        o_bus_wr;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        o_start_next_write;
    logic        o_write_complete;
    logic        o_b2_empty;
    logic        o_b2_full;
`ifdef B2_ERR_FLAG_EN
    logic        o_err;
`endif

    always #5 tb_clk = ~tb_clk;

    b2_write_buffer dut (
        .clk                (tb_clk),
        .rst                (rst),
        .i_b2_save          (i_b2_save),
        .i_grad_pixel       (i_grad_pixel),
        .i_we               (i_we),
        .i_waddr            (i_waddr),
        .i_bus_ack          (i_bus_ack),
        .o_bus_wr           (o_bus_wr),
        .o_bus_addr         (o_bus_addr),
        .o_bus_wdata        (o_bus_wdata),
        .o_start_next_write (o_start_next_write),
        .o_write_complete   (o_write_complete),
        .o_b2_empty         (o_b2_empty),
        .o_b2_full          (o_b2_full)
`ifdef B2_ERR_FLAG_EN
       ,.o_err              (o_err)
`endif
    );

    typedef struct {
        logic [7:0] pix;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_start = 0;
    int         n_done = 0;
    int         n_used = 0;
    int         mcount = 0;
    logic [7:0] exp_q[$];

    always @(negedge tb_clk) begin
        if (o_start_next_write) n_start++;
        if (o_write_complete) n_done++;
    end

    task automatic tick;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_px(input logic [7:0] pix);
        i_b2_save = 1'b1;
        i_grad_pixel = pix;
        if (mcount < B2_DEPTH) begin
            exp_q.push_back(pix);
            mcount++;
        end
        tick;
        i_b2_save = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int t = 0;
        while (n_start == n_used && t < 30) begin
            tick;
            t++;
        end
        ok = (n_start != n_used);
        if (ok) n_used++;
        tick;
    endtask

    task automatic beat(input logic [31:0] addr, input int ack_wait,
                        input bit do_push, input logic [7:0] pix);
        bit ok;
        logic [7:0] ed;
        wait_start(ok);
        check("start_wait", 32'(ok), 32'd1);
        if (!ok) return;
        i_we = 1'b1;
        i_waddr = addr;
        if (do_push) begin
            i_b2_save = 1'b1;
            i_grad_pixel = pix;
            if (mcount < B2_DEPTH) begin
                exp_q.push_back(pix);
                mcount++;
            end
        end
        ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        mcount--;
        tick;
        i_we = 1'b0;
        i_b2_save = 1'b0;
        check("bus_wr_on", 32'(o_bus_wr), 32'd1);
        check("wdata", o_bus_wdata, {24'h0, ed});
        check("addr", o_bus_addr, addr);
        for (int k = 0; k < ack_wait; k++) begin
            tick;
            check("bus_hold", {o_bus_wr, o_bus_wdata}, {1'b1, 24'h0, ed});
            check("addr_hold", o_bus_addr, addr);
        end
        i_bus_ack = 1'b1;
        tick;
        i_bus_ack = 1'b0;
        check("complete", 32'(o_write_complete), 32'd1);
        check("bus_wr_off", 32'(o_bus_wr), 32'd0);
        check("empty_done", 32'(o_b2_empty), 32'(mcount == 0));
    endtask

    initial begin
        vec_t tbl[10];
        bit   ok;
        int   ns;
        int   nd;

        for (int i = 0; i < 9; i++)
            tbl[i] = '{pix: 8'(i + 1), exp_full: (i == 8), exp_empty: 1'b0};
        tbl[9] = '{pix: 8'hFF, exp_full: 1'b1, exp_empty: 1'b0};

        // reset state
        tick;
        check("rst_empty", 32'(o_b2_empty), 32'd1);
        check("rst_full", 32'(o_b2_full), 32'd0);
        check("rst_wr", 32'(o_bus_wr), 32'd0);
        check("rst_addr", o_bus_addr, 32'd0);
        check("rst_wdata", o_bus_wdata, 32'd0);
        check("rst_pulses", {o_start_next_write, o_write_complete}, 32'd0);
        tick;
        rst = 1'b0;
        tick;

        // fill to full, then one dropped push
        for (int i = 0; i < 10; i++) begin
            push_px(tbl[i].pix);
            check("fill_full", 32'(o_b2_full), 32'(tbl[i].exp_full));
            check("fill_empty", 32'(o_b2_empty), 32'(tbl[i].exp_empty));
        end
`ifdef B2_ERR_FLAG_EN
        check("err_full_push", 32'(o_err), 32'd1);
`endif

        // drain nine beats, ack after 3 cycles
        for (int k = 0; k < 9; k++)
            beat(32'h1000 + 32'(4 * k), 3, 1'b0, 8'h00);
        repeat (4) tick;
        check("drain_starts", n_start, 9);
        check("drain_completes", n_done, 9);
        check("drain_empty", 32'(o_b2_empty), 32'd1);

        // simultaneous push and pop with four queued, across pointer wrap
        for (int i = 0; i < 4; i++) push_px(8'h11 + 8'(i));
        for (int k = 0; k < 7; k++) begin
            beat(32'h3000 + 32'(4 * k), 1, 1'b1, 8'h21 + 8'(k));
            check("t4_not_full", 32'(o_b2_full), 32'd0);
        end
        for (int k = 0; k < 4; k++)
            beat(32'h3100 + 32'(4 * k), 0, 1'b0, 8'h00);

        // single-cycle beat
        push_px(8'h5A);
        beat(32'h4000, 0, 1'b0, 8'h00);

        // reset held two cycles mid-BUS
        push_px(8'hA1);
        push_px(8'hA2);
        wait_start(ok);
        check("t1_start", 32'(ok), 32'd1);
        i_we = 1'b1;
        i_waddr = 32'h2000;
        tick;
        i_we = 1'b0;
        check("t1_bus_wr", 32'(o_bus_wr), 32'd1);
        ns = n_start;
        nd = n_done;
        rst = 1'b1;
        i_bus_ack = 1'b1;
        tick;
        check("t1_wr_drop", 32'(o_bus_wr), 32'd0);
        check("t1_empty", 32'(o_b2_empty), 32'd1);
        tick;
        rst = 1'b0;
        tick;
        i_bus_ack = 1'b0;
        exp_q.delete();
        mcount = 0;
        repeat (3) tick;
        check("t1_no_complete", n_done, nd);
        check("t1_no_start", n_start, ns);
        check("t1_wr_idle", 32'(o_bus_wr), 32'd0);
        n_used = n_start;
`ifdef B2_ERR_FLAG_EN
        check("err_cleared", 32'(o_err), 32'd0);
`endif

        // i_we while empty
        i_we = 1'b1;
        i_waddr = 32'h5000;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("t5_no_wr", 32'(o_bus_wr), 32'd0);
            check("t5_no_start", 32'(o_start_next_write), 32'd0);
        end
        i_we = 1'b0;
        tick;
        check("t5_starts", n_start, ns);
`ifdef B2_ERR_FLAG_EN
        check("err_we_empty", 32'(o_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
